// File: rtl/mac_mult_pipe_if.sv
// Operand/result bus of mac_mult_pipe. The sat signal exists only when
// MAC_MULT_PIPE_SAT_EN is defined.
//
// Handshake: a beat moves on any cycle where valid && ready are both high at
// the rising clock edge. A producer may change valid/data freely while ready
// is low, and once out_valid is high the consumer sees stable data until the
// beat is taken.
interface mac_mult_pipe_if #(
  parameter int MIN_WIDTH = 8,
  parameter int LANES     = 4,
  parameter int CFG_WIDTH = 2,
  parameter int ACC_WIDTH = 48
);
  logic                       in_valid;
  logic                       in_ready;
  logic                       in_first;
  logic [CFG_WIDTH-1:0]       cfg;
  logic [MIN_WIDTH-1:0]       b;
  logic [LANES*MIN_WIDTH-1:0] a;
  logic                       out_valid;
  logic                       out_ready;
  logic [ACC_WIDTH-1:0]       out_data;
  logic                       cfg_err;
`ifdef MAC_MULT_PIPE_SAT_EN
  logic                       sat;
`endif

  modport master (
    output in_valid, in_first, cfg, b, a, out_ready,
    input  in_ready, out_valid, out_data, cfg_err
`ifdef MAC_MULT_PIPE_SAT_EN
    , input sat
`endif
  );

  modport slave (
    input  in_valid, in_first, cfg, b, a, out_ready,
    output in_ready, out_valid, out_data, cfg_err
`ifdef MAC_MULT_PIPE_SAT_EN
    , output sat
`endif
  );
endinterface

// File: rtl/mac_mult_pipe.sv
// Precision-configurable multiply-accumulate: 2-stage pipeline with a running accumulator.
// Define MAC_MULT_PIPE_SAT_EN for a saturating accumulator and a sat output flag.
module mac_mult_pipe #(
  parameter int MIN_WIDTH = 8,
  parameter int LANES     = 4,
  parameter int CFG_WIDTH = 2,
  parameter int ACC_WIDTH = 48
) (
  input logic            clk,
  input logic            rst,
  mac_mult_pipe_if.slave bus
);
  localparam int PW        = 2 * MIN_WIDTH;
  localparam int LOG_LANES = $clog2(LANES);

  logic [PW-1:0]        r_pp [LANES];
  logic                 r_s1_valid;
  logic                 r_s1_first;
  logic                 r_s1_err;
  logic                 r_first_pend;
  logic                 r_s2_valid;
  logic [ACC_WIDTH-1:0] r_acc;
  logic                 r_err;

  logic                 w_s1_adv;
  logic                 w_in_fire;
  logic                 w_err;
  logic [PW-1:0]        w_pp [LANES];
  logic [ACC_WIDTH-1:0] w_prod;
  logic [ACC_WIDTH-1:0] w_base;
  logic [ACC_WIDTH-1:0] w_sum;
`ifdef MAC_MULT_PIPE_SAT_EN
  logic                 w_carry;
  logic                 r_sat;
`endif

  // S1 drains into S2 whenever S2 is empty or is being emptied this cycle.
  assign w_s1_adv     = r_s1_valid && (!r_s2_valid || bus.out_ready);
  assign bus.in_ready = !r_s1_valid || w_s1_adv;
  assign w_in_fire    = bus.in_valid && bus.in_ready;
  assign w_err        = (bus.cfg > CFG_WIDTH'(LOG_LANES));

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      w_pp[i] = '0;
      if (!w_err && (i < (1 << bus.cfg)))
        w_pp[i] = PW'(bus.a[i*MIN_WIDTH +: MIN_WIDTH]) * PW'(bus.b);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid   <= 1'b0;
      r_s1_first   <= 1'b0;
      r_s1_err     <= 1'b0;
      r_first_pend <= 1'b1;
      for (int i = 0; i < LANES; i++) r_pp[i] <= '0;
    end else if (w_in_fire) begin
      r_s1_valid   <= 1'b1;
      r_s1_first   <= bus.in_first || r_first_pend;
      r_s1_err     <= w_err;
      r_first_pend <= 1'b0;
      for (int i = 0; i < LANES; i++) r_pp[i] <= w_pp[i];
    end else if (w_s1_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  always_comb begin
    w_prod = '0;
    for (int i = 0; i < LANES; i++)
      w_prod = w_prod + (ACC_WIDTH'(r_pp[i]) << (i * MIN_WIDTH));
  end

  assign w_base = r_s1_first ? '0 : r_acc;
`ifdef MAC_MULT_PIPE_SAT_EN
  assign {w_carry, w_sum} = {1'b0, w_base} + {1'b0, w_prod};
`else
  assign w_sum = w_base + w_prod;
`endif

  // The accumulator is the output register, so a held result is never re-added.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_acc      <= '0;
      r_err      <= 1'b0;
`ifdef MAC_MULT_PIPE_SAT_EN
      r_sat      <= 1'b0;
`endif
    end else if (w_s1_adv) begin
      r_s2_valid <= 1'b1;
      r_err      <= r_s1_err;
`ifdef MAC_MULT_PIPE_SAT_EN
      r_acc      <= w_carry ? '1 : w_sum;
      r_sat      <= w_carry;
`else
      r_acc      <= w_sum;
`endif
    end else if (bus.out_ready) begin
      r_s2_valid <= 1'b0;
    end
  end

  assign bus.out_valid = r_s2_valid;
  assign bus.out_data  = r_acc;
  assign bus.cfg_err   = r_err;
`ifdef MAC_MULT_PIPE_SAT_EN
  assign bus.sat       = r_sat;
`endif
endmodule

// File: tb/tb_mac_mult_pipe.sv
// Directed bench for mac_mult_pipe: a default-sized DUT plus a LANES=1,
// ACC_WIDTH=16 DUT for the wrap/saturate boundary.
module tb_mac_mult_pipe;
  localparam int MW  = 8;
  localparam int LN  = 4;
  localparam int CW  = 2;
  localparam int AW  = 48;
  localparam int AW2 = 16;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mac_mult_pipe_if #(.MIN_WIDTH(MW), .LANES(LN), .CFG_WIDTH(CW), .ACC_WIDTH(AW))  bus ();
  mac_mult_pipe_if #(.MIN_WIDTH(MW), .LANES(1),  .CFG_WIDTH(CW), .ACC_WIDTH(AW2)) bus2 ();

  mac_mult_pipe #(.MIN_WIDTH(MW), .LANES(LN), .CFG_WIDTH(CW), .ACC_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  mac_mult_pipe #(.MIN_WIDTH(MW), .LANES(1), .CFG_WIDTH(CW), .ACC_WIDTH(AW2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_acc    = 0;
  logic [AW:0]  exp_q[$];   // {cfg_err, out_data}
  logic [AW2:0] exp2_q[$];  // {sat or cfg_err, out_data}

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks: called #1 after a rising edge, return #1 after the accepting edge
  task automatic send(input bit first, input logic [CW-1:0] cfg, input logic [MW-1:0] b,
                      input logic [LN*MW-1:0] a, input bit push,
                      input logic [AW-1:0] exp_d, input bit exp_e);
    int t = 0;
    bit took = 1'b0;
    if (push) exp_q.push_back({exp_e, exp_d});
    bus.in_valid = 1'b1;
    bus.in_first = first;
    bus.cfg      = cfg;
    bus.b        = b;
    bus.a        = a;
    forever begin
      @(negedge clk);
      took = bus.in_ready;
      @(posedge clk);
      #1;
      if (took) break;
      t++;
      if (t > 200) begin
        check_eq("send_timeout", 64'd1, 64'd0);
        break;
      end
    end
    if (took) n_acc++;
    bus.in_valid = 1'b0;
  endtask

  task automatic send2(input bit first, input logic [MW-1:0] b, input logic [MW-1:0] a,
                       input logic [AW2:0] exp_v);
    int t = 0;
    bit took = 1'b0;
    exp2_q.push_back(exp_v);
    bus2.in_valid = 1'b1;
    bus2.in_first = first;
    bus2.cfg      = '0;
    bus2.b        = b;
    bus2.a        = a;
    forever begin
      @(negedge clk);
      took = bus2.in_ready;
      @(posedge clk);
      #1;
      if (took) break;
      t++;
      if (t > 200) begin
        check_eq("send2_timeout", 64'd1, 64'd0);
        break;
      end
    end
    bus2.in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || exp2_q.size() != 0) && t < 100) begin
      @(posedge clk);
      t++;
    end
    #1;
    check_eq("drain", 64'(exp_q.size() + exp2_q.size()), 64'd0);
  endtask

  // scoreboard: compare every output transfer against the expected queue
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) check_eq("out_unexpected", {bus.cfg_err, bus.out_data}, 64'd0);
      else check_eq("out", {bus.cfg_err, bus.out_data}, exp_q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!rst && bus2.out_valid && bus2.out_ready) begin
`ifdef MAC_MULT_PIPE_SAT_EN
      if (exp2_q.size() == 0) check_eq("out2_unexpected", {bus2.sat, bus2.out_data}, 64'd0);
      else check_eq("out2", {bus2.sat, bus2.out_data}, exp2_q.pop_front());
`else
      if (exp2_q.size() == 0) check_eq("out2_unexpected", {bus2.cfg_err, bus2.out_data}, 64'd0);
      else check_eq("out2", {bus2.cfg_err, bus2.out_data}, exp2_q.pop_front());
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog n_checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    rst = 1'b1;
    bus.in_valid = 1'b0;  bus.in_first = 1'b0;  bus.cfg = '0;  bus.b = '0;  bus.a = '0;
    bus.out_ready = 1'b1;
    bus2.in_valid = 1'b0; bus2.in_first = 1'b0; bus2.cfg = '0; bus2.b = '0; bus2.a = '0;
    bus2.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check_eq("rst_out_valid", bus.out_valid, 64'd0);
    check_eq("rst_out_data",  bus.out_data,  64'd0);
    check_eq("rst_cfg_err",   bus.cfg_err,   64'd0);
    check_eq("rst_in_ready",  bus.in_ready,  64'd1);

    // single lane, max operands; result valid in the second cycle after acceptance
    send(1'b1, 2'd0, 8'hFF, 32'h0000_00FF, 1'b1, 48'hFE01, 1'b0);
    check_eq("lat_not_yet", bus.out_valid, 64'd0);
    @(posedge clk); #1;
    check_eq("lat_valid", bus.out_valid, 64'd1);
    check_eq("lat_data",  bus.out_data,  64'hFE01);

    // dual and quad lanes
    send(1'b1, 2'd1, 8'h10, 32'h0000_1234, 1'b1, 48'h1_2340, 1'b0);
    send(1'b1, 2'd2, 8'hFF, 32'hFFFF_FFFF, 1'b1, 48'hFE_FFFF_FF01, 1'b0);
    send(1'b1, 2'd2, 8'h02, 32'h0102_0304, 1'b1, 48'h0204_0608, 1'b0);

    // back-to-back accumulation, then restart with in_first
    send(1'b1, 2'd0, 8'h01, 32'h0000_0001, 1'b1, 48'd1, 1'b0);
    send(1'b0, 2'd0, 8'h01, 32'h0000_0002, 1'b1, 48'd3, 1'b0);
    send(1'b0, 2'd0, 8'h01, 32'h0000_0003, 1'b1, 48'd6, 1'b0);
    send(1'b1, 2'd0, 8'h01, 32'h0000_0005, 1'b1, 48'd5, 1'b0);

    // unsupported cfg adds nothing and flags the result; inactive lanes ignored
    send(1'b0, 2'd3, 8'hFF, 32'hFFFF_FFFF, 1'b1, 48'd5, 1'b1);
    send(1'b0, 2'd0, 8'h01, 32'hFFFF_FF01, 1'b1, 48'd6, 1'b0);
    send(1'b0, 2'd1, 8'h10, 32'hABCD_1234, 1'b1, 48'h1_2346, 1'b0);
    drain();

    // backpressure: two beats held, then released in order
    base = n_acc;
    bus.out_ready = 1'b0;
    fork
      begin
        for (int k = 1; k <= 6; k++)
          send(1'b1, 2'd0, 8'h01, 32'(k), 1'b1, 48'(k), 1'b0);
      end
      begin
        repeat (5) @(posedge clk);
        #2;
        check_eq("bp_accepted", 64'(n_acc - base), 64'd2);
        check_eq("bp_in_ready", bus.in_ready,  64'd0);
        check_eq("bp_valid",    bus.out_valid, 64'd1);
        check_eq("bp_hold",     bus.out_data,  64'd1);
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // mid-stream reset discards in-flight beats and re-arms the first-beat flag
    bus.out_ready = 1'b0;
    send(1'b1, 2'd0, 8'h01, 32'd7, 1'b0, 48'd0, 1'b0);
    send(1'b1, 2'd0, 8'h01, 32'd8, 1'b0, 48'd0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("mrst_out_valid", bus.out_valid, 64'd0);
    check_eq("mrst_out_data",  bus.out_data,  64'd0);
    check_eq("mrst_cfg_err",   bus.cfg_err,   64'd0);
    check_eq("mrst_in_ready",  bus.in_ready,  64'd1);
    bus.out_ready = 1'b1;
    send(1'b0, 2'd0, 8'h02, 32'd9, 1'b1, 48'd18, 1'b0);
    drain();

    // 16-bit accumulator boundary: wrap by default, saturate with the macro
    send2(1'b1, 8'hFF, 8'hFF, {1'b0, 16'hFE01});
`ifdef MAC_MULT_PIPE_SAT_EN
    send2(1'b0, 8'hFF, 8'hFF, {1'b1, 16'hFFFF});
    send2(1'b0, 8'h01, 8'h01, {1'b1, 16'hFFFF});
    send2(1'b1, 8'h01, 8'h03, {1'b0, 16'h0003});
`else
    send2(1'b0, 8'hFF, 8'hFF, {1'b0, 16'hFC02});
    send2(1'b0, 8'h01, 8'h01, {1'b0, 16'hFC03});
    send2(1'b1, 8'h01, 8'h03, {1'b0, 16'h0003});
`endif
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
